// File: rtl/dram_port_arbiter_pkg.sv
// Shared definitions for the data-RAM port arbiter.
//   - FSM state encodings (IDLE / ACCESS / RESP)
//   - requester id constants (M0 = CPU MEM stage, M1 = debug/DMA loader)
//   - data_ram control levels (chip enable, write enable, zero word)
//   - addr_in_range(): 1 when a byte address falls inside the RAM
package dram_port_arbiter_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_RESP   = 2'd2
    } state_e;

    localparam logic M0 = 1'b0;
    localparam logic M1 = 1'b1;

    localparam logic        CHIP_ENABLE   = 1'b1;
    localparam logic        CHIP_DISABLE  = 1'b0;
    localparam logic        WRITE_ENABLE  = 1'b1;
    localparam logic        WRITE_DISABLE = 1'b0;
    localparam logic [31:0] ZERO_WORD     = 32'h0000_0000;

    // Every address bit above the word index must be zero.
    function automatic logic addr_in_range(input logic [31:0] addr,
                                           input int unsigned mem_log2);
        return (addr >> (mem_log2 + 2)) == 32'h0;
    endfunction

endpackage

// File: rtl/dram_rr_pick.sv
// Combinational winner selection for the two-requester RAM arbiter.
//   req[1:0]    : request lines, bit i = requester i
//   last_grant  : id of the most recent winner
//   grant_id    : id of the winner (valid only with grant_valid)
//   grant_valid : at least one request is pending
// FIXED_PRIO != 0 makes m0 win every tie; otherwise a tie goes to the
// requester that did not win last time.
module dram_rr_pick
    import dram_port_arbiter_pkg::*;
#(
    parameter int unsigned FIXED_PRIO = 0
) (
    input  logic [1:0] req,
    input  logic       last_grant,
    output logic       grant_id,
    output logic       grant_valid
);

    always_comb begin
        grant_valid = |req;
        grant_id    = M0;
        unique case (req)
            2'b01:   grant_id = M0;
            2'b10:   grant_id = M1;
            2'b11:   grant_id = (FIXED_PRIO != 0) ? M0 : ~last_grant;
            default: grant_id = M0;
        endcase
    end

endmodule

// File: rtl/dram_port_arbiter.sv
// Shares the single-port data RAM between the CPU MEM stage (m0) and the
// debug/DMA loader (m1). One access at a time: IDLE picks and latches a
// winner, ACCESS drives the RAM for one cycle, RESP pulses the winner's
// ack. Out-of-range addresses skip ACCESS and are acked with err=1.
// Ports:
//   clk, rst            : clock, synchronous active-low reset
//   m{0,1}_req/we/addr/sel/wdata : requester inputs, held until ack
//   m{0,1}_rdata/ack/err         : one-cycle response to the winner
//   stallreq            : m0 access outstanding (m0_req & ~m0_ack)
//   ram_ce/we/addr/sel/data, ram_rdata : data_ram interface
//   busy                : FSM is in ACCESS or RESP
module dram_port_arbiter
    import dram_port_arbiter_pkg::*;
#(
    parameter int unsigned DATA_MEM_NUM_LOG2 = 17,
    parameter int unsigned FIXED_PRIO        = 0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        m0_req,
    input  logic        m0_we,
    input  logic [31:0] m0_addr,
    input  logic [3:0]  m0_sel,
    input  logic [31:0] m0_wdata,
    output logic [31:0] m0_rdata,
    output logic        m0_ack,
    output logic        m0_err,
    input  logic        m1_req,
    input  logic        m1_we,
    input  logic [31:0] m1_addr,
    input  logic [3:0]  m1_sel,
    input  logic [31:0] m1_wdata,
    output logic [31:0] m1_rdata,
    output logic        m1_ack,
    output logic        m1_err,
    output logic        stallreq,
    output logic        ram_ce,
    output logic        ram_we,
    output logic [31:0] ram_addr,
    output logic [3:0]  ram_sel,
    output logic [31:0] ram_data,
    input  logic [31:0] ram_rdata,
    output logic        busy
);

    state_e      state_q, state_d;
    logic        last_grant_q, last_grant_d;
    logic        id_q, id_d;
    logic        we_q, we_d;
    logic        ram_ce_q, ram_ce_d;
    logic        ram_we_q, ram_we_d;
    logic [31:0] ram_addr_q, ram_addr_d;
    logic [3:0]  ram_sel_q, ram_sel_d;
    logic [31:0] ram_data_q, ram_data_d;
    logic        m0_ack_q, m0_ack_d, m1_ack_q, m1_ack_d;
    logic        m0_err_q, m0_err_d, m1_err_q, m1_err_d;
    logic [31:0] m0_rdata_q, m0_rdata_d, m1_rdata_q, m1_rdata_d;
    logic        busy_q, busy_d;

    logic        grant_id, grant_valid;
    logic        win_we;
    logic [31:0] win_addr, win_wdata, rd_word;
    logic [3:0]  win_sel;

    dram_rr_pick #(
        .FIXED_PRIO (FIXED_PRIO)
    ) u_pick (
        .req         ({m1_req, m0_req}),
        .last_grant  (last_grant_q),
        .grant_id    (grant_id),
        .grant_valid (grant_valid)
    );

    assign win_we    = (grant_id == M1) ? m1_we    : m0_we;
    assign win_addr  = (grant_id == M1) ? m1_addr  : m0_addr;
    assign win_sel   = (grant_id == M1) ? m1_sel   : m0_sel;
    assign win_wdata = (grant_id == M1) ? m1_wdata : m0_wdata;

    // Writes return zero; reads capture the RAM word at the ACCESS edge.
    assign rd_word = we_q ? ZERO_WORD : ram_rdata;

    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        id_d         = id_q;
        we_d         = we_q;
        // Pulse-style outputs default to idle so the RAM never sees a
        // stray enable and acks last exactly one cycle.
        ram_ce_d     = CHIP_DISABLE;
        ram_we_d     = WRITE_DISABLE;
        ram_addr_d   = ZERO_WORD;
        ram_sel_d    = 4'b0000;
        ram_data_d   = ZERO_WORD;
        m0_ack_d     = 1'b0;
        m0_err_d     = 1'b0;
        m0_rdata_d   = ZERO_WORD;
        m1_ack_d     = 1'b0;
        m1_err_d     = 1'b0;
        m1_rdata_d   = ZERO_WORD;
        busy_d       = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (grant_valid) begin
                    last_grant_d = grant_id;
                    id_d         = grant_id;
                    we_d         = win_we;
                    busy_d       = 1'b1;
                    if (addr_in_range(win_addr, DATA_MEM_NUM_LOG2)) begin
                        // The ram_* flops double as the latched access
                        // fields; they are live only during ACCESS.
                        state_d    = ST_ACCESS;
                        ram_ce_d   = CHIP_ENABLE;
                        ram_we_d   = win_we ? WRITE_ENABLE : WRITE_DISABLE;
                        ram_addr_d = win_addr;
                        ram_sel_d  = win_sel;
                        ram_data_d = win_wdata;
                    end else begin
                        // No RAM access: answer with err straight away.
                        state_d = ST_RESP;
                        if (grant_id == M1) begin
                            m1_ack_d = 1'b1;
                            m1_err_d = 1'b1;
                        end else begin
                            m0_ack_d = 1'b1;
                            m0_err_d = 1'b1;
                        end
                    end
                end
            end
            ST_ACCESS: begin
                state_d = ST_RESP;
                busy_d  = 1'b1;
                if (id_q == M1) begin
                    m1_ack_d   = 1'b1;
                    m1_rdata_d = rd_word;
                end else begin
                    m0_ack_d   = 1'b1;
                    m0_rdata_d = rd_word;
                end
            end
            // The winner's req is still high here; returning to IDLE
            // without looking at it prevents a double grant.
            ST_RESP: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q      <= ST_IDLE;
            last_grant_q <= M1;
            id_q         <= M0;
            we_q         <= 1'b0;
            ram_ce_q     <= CHIP_DISABLE;
            ram_we_q     <= WRITE_DISABLE;
            ram_addr_q   <= ZERO_WORD;
            ram_sel_q    <= 4'b0000;
            ram_data_q   <= ZERO_WORD;
            m0_ack_q     <= 1'b0;
            m0_err_q     <= 1'b0;
            m0_rdata_q   <= ZERO_WORD;
            m1_ack_q     <= 1'b0;
            m1_err_q     <= 1'b0;
            m1_rdata_q   <= ZERO_WORD;
            busy_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            id_q         <= id_d;
            we_q         <= we_d;
            ram_ce_q     <= ram_ce_d;
            ram_we_q     <= ram_we_d;
            ram_addr_q   <= ram_addr_d;
            ram_sel_q    <= ram_sel_d;
            ram_data_q   <= ram_data_d;
            m0_ack_q     <= m0_ack_d;
            m0_err_q     <= m0_err_d;
            m0_rdata_q   <= m0_rdata_d;
            m1_ack_q     <= m1_ack_d;
            m1_err_q     <= m1_err_d;
            m1_rdata_q   <= m1_rdata_d;
            busy_q       <= busy_d;
        end
    end

    assign ram_ce   = ram_ce_q;
    assign ram_we   = ram_we_q;
    assign ram_addr = ram_addr_q;
    assign ram_sel  = ram_sel_q;
    assign ram_data = ram_data_q;
    assign m0_ack   = m0_ack_q;
    assign m0_err   = m0_err_q;
    assign m0_rdata = m0_rdata_q;
    assign m1_ack   = m1_ack_q;
    assign m1_err   = m1_err_q;
    assign m1_rdata = m1_rdata_q;
    assign busy     = busy_q;
    assign stallreq = m0_req & ~m0_ack_q;

endmodule

// File: tb/tb_dram_port_arbiter.sv
// Scoreboard bench for dram_port_arbiter. The driver pushes the expected
// ack (requester, err, rdata) into a queue; a negedge monitor pops and
// compares whenever an ack appears. A second instance with FIXED_PRIO=1
// covers fixed-priority contention.
module tb_dram_port_arbiter;

    typedef struct packed {
        logic        id;
        logic        err;
        logic [31:0] rdata;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        m0_req = 1'b0, m0_we = 1'b0, m1_req = 1'b0, m1_we = 1'b0;
    logic [31:0] m0_addr = '0, m0_wdata = '0, m1_addr = '0, m1_wdata = '0;
    logic [3:0]  m0_sel = '0, m1_sel = '0;
    logic [31:0] m0_rdata, m1_rdata, ram_addr, ram_data, ram_rdata;
    logic        m0_ack, m0_err, m1_ack, m1_err, stallreq, ram_ce, ram_we, busy;
    logic [3:0]  ram_sel;

    // FIXED_PRIO=1 instance
    logic        f_m0_req = 1'b0, f_m1_req = 1'b0;
    logic        f_we = 1'b0;
    logic [31:0] f_addr = '0, f_wdata = '0, f_ram_rdata = '0;
    logic [3:0]  f_sel = 4'hF;
    logic [31:0] f_m0_rdata, f_m1_rdata, f_ram_addr, f_ram_data;
    logic        f_m0_ack, f_m0_err, f_m1_ack, f_m1_err, f_stallreq;
    logic        f_ram_ce, f_ram_we, f_busy;
    logic [3:0]  f_ram_sel;

    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    int   acks_seen = 0;
    int   f0_acks = 0;
    int   f1_acks = 0;
    logic ce_seen = 1'b0;
    exp_t exp_q[$];
    int   ack_cyc[$];
    logic [31:0] mem [0:255];

    always #5 clk = ~clk;

    dram_port_arbiter #(.DATA_MEM_NUM_LOG2(17), .FIXED_PRIO(0)) dut (
        .clk(clk), .rst(rst),
        .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr), .m0_sel(m0_sel),
        .m0_wdata(m0_wdata), .m0_rdata(m0_rdata), .m0_ack(m0_ack), .m0_err(m0_err),
        .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr), .m1_sel(m1_sel),
        .m1_wdata(m1_wdata), .m1_rdata(m1_rdata), .m1_ack(m1_ack), .m1_err(m1_err),
        .stallreq(stallreq), .ram_ce(ram_ce), .ram_we(ram_we), .ram_addr(ram_addr),
        .ram_sel(ram_sel), .ram_data(ram_data), .ram_rdata(ram_rdata), .busy(busy)
    );

    dram_port_arbiter #(.DATA_MEM_NUM_LOG2(17), .FIXED_PRIO(1)) u_fix (
        .clk(clk), .rst(rst),
        .m0_req(f_m0_req), .m0_we(f_we), .m0_addr(f_addr), .m0_sel(f_sel),
        .m0_wdata(f_wdata), .m0_rdata(f_m0_rdata), .m0_ack(f_m0_ack), .m0_err(f_m0_err),
        .m1_req(f_m1_req), .m1_we(f_we), .m1_addr(f_addr), .m1_sel(f_sel),
        .m1_wdata(f_wdata), .m1_rdata(f_m1_rdata), .m1_ack(f_m1_ack), .m1_err(f_m1_err),
        .stallreq(f_stallreq), .ram_ce(f_ram_ce), .ram_we(f_ram_we), .ram_addr(f_ram_addr),
        .ram_sel(f_ram_sel), .ram_data(f_ram_data), .ram_rdata(f_ram_rdata), .busy(f_busy)
    );

    // Small RAM model: combinational read, byte-enabled write on posedge.
    assign ram_rdata = mem[ram_addr[9:2]];
    always @(posedge clk) begin
        if (ram_ce && ram_we) begin
            for (int b = 0; b < 4; b++)
                if (ram_sel[b]) mem[ram_addr[9:2]][8*b +: 8] <= ram_data[8*b +: 8];
        end
    end

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // Monitor: every ack is checked against the head of the scoreboard.
    always @(negedge clk) begin
        exp_t got, e;
        if (ram_ce === 1'b1) ce_seen = 1'b1;
        if (f_m0_ack === 1'b1) f0_acks++;
        if (f_m1_ack === 1'b1) f1_acks++;
        if (m0_ack === 1'b1 && m1_ack === 1'b1) begin
            chk("both_acked", {m0_ack, m1_ack}, 64'h1);
        end else if (m0_ack === 1'b1 || m1_ack === 1'b1) begin
            got.id    = m1_ack;
            got.err   = m1_ack ? m1_err : m0_err;
            got.rdata = m1_ack ? m1_rdata : m0_rdata;
            acks_seen++;
            ack_cyc.push_back(cyc);
            if (exp_q.size() == 0) begin
                chk("unexpected_ack", {got.id, got.err, got.rdata}, 64'h0);
            end else begin
                e = exp_q.pop_front();
                chk("ack_resp{id,err,rdata}", {got.id, got.err, got.rdata},
                    {e.id, e.err, e.rdata});
                if (m1_ack) chk("m0_idle_outs", {m0_err, m0_rdata}, 64'h0);
                else        chk("m1_idle_outs", {m1_err, m1_rdata}, 64'h0);
            end
        end
    end

    // One complete access; latency counted in posedges from req raise.
    task automatic do_req(input logic id, input logic we, input logic [31:0] addr,
                          input logic [3:0] sel, input logic [31:0] wdata,
                          input logic exp_err, input logic [31:0] exp_rd,
                          input int exp_lat);
        exp_t e;
        int   k;
        logic ack;
        e.id = id; e.err = exp_err; e.rdata = exp_rd;
        exp_q.push_back(e);
        ce_seen = 1'b0;
        if (id) begin
            m1_we = we; m1_addr = addr; m1_sel = sel; m1_wdata = wdata; m1_req = 1'b1;
        end else begin
            m0_we = we; m0_addr = addr; m0_sel = sel; m0_wdata = wdata; m0_req = 1'b1;
        end
        k = 0;
        ack = 1'b0;
        while (!ack && k < 10) begin
            @(posedge clk); #1;
            k++;
            ack = id ? m1_ack : m0_ack;
            if (!ack && !id) chk("stallreq_pending", stallreq, 1);
        end
        if (!ack) chk("ack_timeout", 0, 1);
        chk("ack_latency", k, exp_lat);
        if (!id) chk("stallreq_in_ack", stallreq, 0);
        chk("ram_ce_seen", ce_seen, !exp_err);
        @(posedge clk); #1;
        m0_req = 1'b0; m1_req = 1'b0;
        chk("idle_after_resp", busy, 0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int n, k;
        for (int i = 0; i < 256; i++) mem[i] = 32'hA500_0000 | i;

        // Reset with both requests high; expected order afterwards is
        // m0, m1, m0, m1 (round robin, m0 first).
        m0_req = 1'b1; m0_we = 1'b0; m0_addr = 32'h20; m0_sel = 4'hF;
        m1_req = 1'b1; m1_we = 1'b0; m1_addr = 32'h40; m1_sel = 4'hF;
        for (int i = 0; i < 4; i++) begin
            exp_t e;
            e.id = i[0]; e.err = 1'b0;
            e.rdata = i[0] ? 32'hA500_0010 : 32'hA500_0008;
            exp_q.push_back(e);
        end
        repeat (3) begin
            @(posedge clk); #1;
            chk("reset_outputs", {ram_ce, ram_we, ram_addr, ram_sel, m0_ack, m0_err,
                                  m1_ack, m1_err, busy}, 64'h0);
            chk("reset_data", {ram_data, m0_rdata}, 64'h0);
            chk("reset_m1_rdata", m1_rdata, 0);
        end
        rst = 1'b1;
        k = 0;
        while (acks_seen < 4 && k < 30) begin
            @(posedge clk); #1;
            k++;
        end
        if (acks_seen < 4) chk("contention_timeout", acks_seen, 4);
        m0_req = 1'b0; m1_req = 1'b0;
        chk("rr_queue_drained", exp_q.size(), 0);
        for (int i = 0; i + 1 < ack_cyc.size(); i++)
            chk("rr_ack_spacing", ack_cyc[i+1] - ack_cyc[i], 3);
        @(posedge clk); #1;

        // Write/read, byte write, empty-sel write, boundaries.
        do_req(1'b0, 1'b1, 32'h0000_0010, 4'b1111, 32'hDEADBEEF, 1'b0, 32'h0, 2);
        do_req(1'b0, 1'b0, 32'h0000_0010, 4'b1111, 32'h0,        1'b0, 32'hDEADBEEF, 2);
        do_req(1'b1, 1'b1, 32'h0000_0010, 4'b0001, 32'h0000_00AA, 1'b0, 32'h0, 2);
        do_req(1'b0, 1'b0, 32'h0000_0010, 4'b1111, 32'h0,        1'b0, 32'hDEADBEAA, 2);
        do_req(1'b1, 1'b1, 32'h0000_0010, 4'b0000, 32'h12345678, 1'b0, 32'h0, 2);
        do_req(1'b1, 1'b0, 32'h0000_0010, 4'b1111, 32'h0,        1'b0, 32'hDEADBEAA, 2);
        do_req(1'b1, 1'b0, 32'h8000_0000, 4'b1111, 32'h0,        1'b1, 32'h0, 1);
        do_req(1'b0, 1'b0, 32'h0008_0000, 4'b1111, 32'h0,        1'b1, 32'h0, 1);
        do_req(1'b1, 1'b0, 32'h0007_FFFC, 4'b1111, 32'h0,        1'b0, 32'hA500_00FF, 2);

        // Reset during ACCESS of a read: no ack, back to idle.
        n = acks_seen;
        m0_we = 1'b0; m0_addr = 32'h10; m0_sel = 4'hF; m0_req = 1'b1;
        @(posedge clk); #1;
        chk("midreset_access", {busy, ram_ce, ram_we, ram_addr}, {3'b110, 32'h10});
        rst = 1'b0;
        @(posedge clk); #1;
        chk("midreset_cleared", {busy, ram_ce, m0_ack, m1_ack}, 64'h0);
        rst = 1'b1; m0_req = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        chk("midreset_no_ack", acks_seen, n);

        // Fixed priority: both held for 15 edges -> five m0 acks, no m1.
        f_m0_req = 1'b1; f_m1_req = 1'b1;
        repeat (15) @(posedge clk);
        #1;
        f_m0_req = 1'b0; f_m1_req = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("fixed_m1_acks", f1_acks, 0);
        chk("fixed_m0_acks", f0_acks, 5);
        chk("final_queue_empty", exp_q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
